write_back_buffer: RTL and testbench

//  Queues dirty words evicted by the two-way data cache and drains them to main memory one word per accepted cycle.

---
 rtl/wb_buffer_pkg.sv | 17 +
 rtl/wb_match_unit.sv | 33 +++
 rtl/write_back_buffer.sv | 106 ++++++++++
 tb/tb_write_back_buffer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wb_buffer_pkg.sv
// Shared types and helpers for the write-back buffer.
// Entry widths follow WB_ADDR_WIDTH / WB_DATA_WIDTH below.
package wb_buffer_pkg;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Circular pointer increment; wraps to 0 at depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/wb_match_unit.sv
// Parallel address compare over all buffer entries.
// When several entries match, the youngest (furthest from head) wins.
module wb_match_unit
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0]    entries,
  input  logic [PTR_W-1:0]         head,
  input  logic [WB_ADDR_WIDTH-1:0] key,
  output logic                     hit,
  output logic [PTR_W-1:0]         hit_idx,
  output logic [WB_DATA_WIDTH-1:0] hit_data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (entries[idx].valid && entries[idx].addr == key) begin
        hit      = 1'b1;
        hit_idx  = idx;
        hit_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer between cache evictions and the RAM write port.
// Circular FIFO of dirty words, drained one per accepted RAM cycle, with
// zero-latency read forwarding so miss refills never see stale RAM data.
// Optional WB_COALESCE_EN: evictions hitting a buffered address update it in place.
module write_back_buffer
  import wb_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evict_valid,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  input  logic [DATA_WIDTH-1:0] evict_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_ram,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wd,
  input  logic                  ram_ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W:0]        count;
  logic                  drain, append, coalesce;
  logic [PTR_W-1:0]      co_idx;
  logic                  fw_hit;
  logic [PTR_W-1:0]      fw_idx;
  logic [DATA_WIDTH-1:0] fw_data;
  logic                  unused_fw_idx;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign ram_we    = (count != '0);
  assign ram_waddr = entries[head].addr;
  assign ram_wd    = entries[head].data;
  assign drain     = ram_we && ram_ready;

  // Forwarding sees only registered entries, so a same-cycle eviction is
  // not forwarded while the draining head still is.
  wb_match_unit #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .head    (head),
    .key     (rd_addr),
    .hit     (fw_hit),
    .hit_idx (fw_idx),
    .hit_data(fw_data)
  );
  assign rd_data       = fw_hit ? fw_data : rd_data_ram;
  assign unused_fw_idx = ^fw_idx;

`ifdef WB_COALESCE_EN
  logic                  co_hit;
  logic [DATA_WIDTH-1:0] co_data_unused;

  wb_match_unit #(.DEPTH(DEPTH)) u_coal (
    .entries (entries),
    .head    (head),
    .key     (evict_addr),
    .hit     (co_hit),
    .hit_idx (co_idx),
    .hit_data(co_data_unused)
  );
  // A head that leaves this cycle cannot absorb the word; it appends instead.
  assign coalesce = evict_valid && co_hit && !(drain && co_idx == head);
`else
  assign co_idx   = '0;
  assign coalesce = 1'b0;
`endif

  // A full buffer still accepts when the head drains in the same cycle.
  assign append = evict_valid && !coalesce && (count != DEPTH_C || drain);

  // FIFO state: drain at head, append at tail, in-place coalesce, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drain) begin
        entries[head].valid <= 1'b0;
        head                <= PTR_W'(ptr_inc(32'(head), DEPTH));
      end
      if (coalesce) entries[co_idx].data <= evict_data;
      // Append last: when full with drain, tail==head and the new word must win.
      if (append) begin
        entries[tail] <= '{valid: 1'b1, addr: evict_addr, data: evict_data};
        tail          <= PTR_W'(ptr_inc(32'(tail), DEPTH));
      end
      if (evict_valid && !coalesce && !append) overflow <= 1'b1;
      count <= count + (PTR_W+1)'(append) - (PTR_W+1)'(drain);
    end
  end
endmodule

// File: tb/tb_write_back_buffer.sv
// Scoreboard bench for write_back_buffer: the stimulus side keeps a queue
// model of buffered words and pushes per-cycle expectations; a negedge
// monitor pops and compares status, forwarding and drained words.
module tb_write_back_buffer;
  localparam int DW = 32, AW = 32, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          evict_valid;
  logic [AW-1:0] evict_addr;
  logic [DW-1:0] evict_data;
  logic          full, empty, overflow;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_ram, rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wd;
  logic          ram_ready;

  write_back_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .full(full), .empty(empty), .overflow(overflow),
    .rd_addr(rd_addr), .rd_data_ram(rd_data_ram), .rd_data(rd_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wd(ram_wd), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  typedef struct {logic [DW-1:0] rd; bit full, empty, ovf;} stat_t;

  ent_t  model_q[$];   // buffered words, oldest first
  stat_t stat_q[$];    // expected per-cycle status
  bit    ovf_m;
  int    n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and update the model from the buffer's rules.
  task automatic cycle(input bit ev, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit rdy, input logic [AW-1:0] ra);
    stat_t s;
    bit    drn, done;
    evict_valid = ev; evict_addr = a; evict_data = d;
    ram_ready = rdy; rd_addr = ra; rd_data_ram = $urandom;
    s.rd = rd_data_ram;
    foreach (model_q[i]) if (model_q[i].a == ra) s.rd = model_q[i].d;
    s.full  = (model_q.size() == DEPTH);
    s.empty = (model_q.size() == 0);
    s.ovf   = ovf_m;
    stat_q.push_back(s);
    drn  = (model_q.size() != 0) && rdy;
    done = 1'b0;
    if (ev) begin
`ifdef WB_COALESCE_EN
      begin
        int idx;
        idx = -1;
        foreach (model_q[i]) if (model_q[i].a == a) idx = i;
        if (idx > 0 || (idx == 0 && !drn)) begin
          model_q[idx].d = d;
          done = 1'b1;
        end
      end
`endif
      if (!done) begin
        if (model_q.size() < DEPTH || drn) model_q.push_back('{a, d});
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_ram_waddr"}, 64'(ram_waddr), 64'd0);
    chk({tag, "_ram_wd"}, 64'(ram_wd), 64'd0);
    model_q.delete();
    stat_q.delete();
    ovf_m = 1'b0;
    evict_valid = 1'b0; ram_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: compare status every cycle and every drained word against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stat_q.size() > 0) begin
        stat_t s;
        s = stat_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(s.rd));
        chk("full", 64'(full), 64'(s.full));
        chk("empty", 64'(empty), 64'(s.empty));
        chk("ram_we", 64'(ram_we), 64'(!s.empty));
        chk("overflow", 64'(overflow), 64'(s.ovf));
      end
      if (ram_we && ram_ready) begin
        if (model_q.size() == 0) chk("drain_unexpected", 64'd1, 64'd0);
        else begin
          ent_t e;
          e = model_q.pop_front();
          chk("drain_addr", 64'(ram_waddr), 64'(e.a));
          chk("drain_data", 64'(ram_wd), 64'(e.d));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    rd_addr = '0; rd_data_ram = '0; ram_ready = 1'b0;
    ovf_m = 1'b0;
    #2;
    do_reset("reset");

    // Single eviction, held, then one drain.
    cycle(1, 32'h100, 32'hAA, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h100);
    cycle(0, 0, 0, 1, 32'h100);
    cycle(0, 0, 0, 0, 32'h100);

    // Fill to full, overflow on fifth, then full + drain + evict, then drain all.
    for (int i = 0; i < 5; i++) cycle(1, 32'h400 + 32'(4*i), 32'hB0 + 32'(i), 0, 32'h404);
    cycle(0, 0, 0, 0, 32'h410);
    cycle(1, 32'h500, 32'hC5, 1, 32'h500);
    cycle(0, 0, 0, 0, 32'h500);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h408);
    do_reset("reset_ovf");

    // Forwarding hit and miss.
    cycle(1, 32'h200, 32'h11, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h200);
    cycle(0, 0, 0, 0, 32'h204);
    cycle(0, 0, 0, 1, 32'h200);
    cycle(0, 0, 0, 0, 32'h200);

    // Duplicate address evictions.
    cycle(1, 32'h300, 32'h1, 0, 32'h300);
    cycle(1, 32'h300, 32'h2, 0, 32'h300);
    cycle(0, 0, 0, 0, 32'h300);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h300);

    // Pointer wrap: ten enqueue-while-draining cycles, then reset mid-drain.
    for (int i = 0; i < 10; i++) cycle(1, 32'h600 + 32'(4*i), $urandom, 1, 32'h600 + 32'(4*i));
    cycle(1, 32'h700, 32'h77, 0, 32'h700);
    cycle(1, 32'h704, 32'h78, 0, 32'h700);
    ram_ready = 1'b1;
    #2;
    do_reset("reset_mid_drain");

    // Randomized traffic over a small address pool so hits and duplicates occur.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 60, 32'h100 + 32'(4*$urandom_range(0, 5)), $urandom,
            $urandom_range(0, 99) < 45, 32'h100 + 32'(4*$urandom_range(0, 6)));
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 32'h100);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
